cache_control: RTL and testbench
================================

Name: cache_control

Overview:
- FSM that sequences the 2-way set-associative L1 cache datapath: hit service, dirty-victim writeback, line allocate and refill.
- Sits between the CPU memory port, the cache datapath (hit/dirty/replace in; pmem_we, pmarmux_sel, datamux_sel, load_addr out) and the 256-bit physical memory port.
- Also keeps saturating hit, miss and writeback counters for performance analysis.

Parameters:
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  CPU request complete (one-cycle pulse)
hit  in  1  datapath: tag match in either way
dirty  in  1  datapath: LRU victim way is dirty
replace  in  1  datapath: LRU victim way is valid
pmem_resp  in  1  physical memory: line transfer complete
pmem_read  out  1  physical memory line read request
pmem_write  out  1  physical memory line write request
pmem_we  out  1  datapath: load tag/valid/data/dirty of victim way from pmem_rdata
pmarmux_sel  out  1  datapath: 0 = request tag, 1 = victim tag for pmem_address
datamux_sel  out  1  datapath: 0 = pmem_rdata, 1 = merged CPU write data
load_addr  out  1  datapath: latch pmem_address register
hit_count  out  CNT_WIDTH  first-access hits
miss_count  out  CNT_WIDTH  misses
wb_count  out  CNT_WIDTH  dirty writebacks

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous, active-high.
- States: S_CHECK, S_WRITEBACK, S_ALLOC, S_REFILL.
- Reset state: S_CHECK. Counters reset to 0.
- While rst=1, every output, including the combinational ones, is forced to 0.
- An rst assertion mid-miss aborts the transfer. pmem_read/pmem_write drop in the cycle rst is high, and no array write occurs.
- Default value of all control outputs is 0. datamux_sel defaults to 1.
- S_CHECK, no request: all control outputs 0; stay in S_CHECK.
- S_CHECK, request and hit=1:
  - mem_resp=1 in the same cycle (zero added latency).
  - The datapath performs the write-hit merge (datamux_sel=1).
  - If refill_flag=0, hit_count increments; clear refill_flag.
  - Stay in S_CHECK.
- S_CHECK, request, hit=0, replace=1 and dirty=1:
  - load_addr=1, pmarmux_sel=1 (latches the victim address).
  - miss_count increments; go to S_WRITEBACK.
- S_CHECK, request, hit=0, otherwise:
  - load_addr=1, pmarmux_sel=0.
  - miss_count increments; go to S_ALLOC.
- S_WRITEBACK:
  - pmem_write=1 and pmarmux_sel=1, held until pmem_resp.
  - On pmem_resp: wb_count increments; load_addr=1 with pmarmux_sel=0 (latches the allocate address); go to S_ALLOC.
- S_ALLOC:
  - pmem_read=1 and datamux_sel=0, held until pmem_resp.
  - On pmem_resp: pmem_we=1 (way fill, valid=1, dirty=0); go to S_REFILL.
- S_REFILL:
  - One settle cycle with all control outputs 0 and datamux_sel=1.
  - Set refill_flag; go to S_CHECK, where the retried access hits and completes.
  - A write miss therefore completes as a write hit after refill, which sets dirty.
- Miss latency with no writeback: 1 (CHECK) + N (ALLOC, pmem_resp on the Nth cycle) + 1 (REFILL) + 1 (CHECK hit) cycles.
- pmem_read and pmem_write are never both 1.
- pmem_resp outside S_WRITEBACK/S_ALLOC is ignored.
- mem_read and mem_write both 1: treated as a write.
- A request dropped during a miss: the fill completes anyway. S_CHECK then sees no request, asserts no mem_resp and clears refill_flag.
- Counters saturate at all-ones and never wrap.
- At most one counter increments per cycle.

Test Plan:
- Reset with mem_read=1, hit=1 -> mem_resp=0 while rst=1. All counters are 0 after reset.
- Read, hit=1 -> mem_resp=1 in the same cycle; hit_count=1; no pmem activity.
- Read miss, replace=0, pmem_resp on the 3rd S_ALLOC cycle:
  - load_addr=1 with pmarmux_sel=0 in cycle 0.
  - pmem_read=1 for cycles 1-3; pmem_we=1 in cycle 3.
  - REFILL in cycle 4; CHECK with hit=1 in cycle 5 gives mem_resp=1.
  - miss_count=1, hit_count=0.
- Write miss, replace=1, dirty=1:
  - pmarmux_sel=1 during pmem_write until pmem_resp.
  - Then load_addr=1 with pmarmux_sel=0, then pmem_read.
  - wb_count=1, miss_count=1; final mem_resp with datamux_sel=1.
- rst asserted during S_WRITEBACK -> pmem_write=0 that cycle; state returns to S_CHECK; pmem_we never pulses.
- CNT_WIDTH=4, 17 consecutive read hits -> hit_count holds at 15.

Source files
------------

// File: rtl/cache_control.sv
// cache_control: sequencing FSM for a 2-way set-associative L1 cache.
// It services hits with zero added latency. On a miss it writes back a dirty
// victim when needed, then allocates and refills the line, and the CPU access
// is retried in S_CHECK. Saturating hit/miss/writeback counters are kept for
// performance analysis.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  // CPU memory port
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  // datapath status
  input  logic                 hit,
  input  logic                 dirty,
  input  logic                 replace,
  // physical memory port
  input  logic                 pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  // datapath control
  output logic                 pmem_we,
  output logic                 pmarmux_sel,
  output logic                 datamux_sel,
  output logic                 load_addr,
  // performance counters
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    S_CHECK,
    S_WRITEBACK,
    S_ALLOC,
    S_REFILL
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 refill_q, refill_d;   // the current CHECK is the retry after a fill
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;

  logic request;
  logic inc_hit, inc_miss, inc_wb;

  // A simultaneous read and write is handled as a write; the control
  // sequence is identical, so only the presence of a request matters here.
  assign request = mem_read | mem_write;

  // Next-state and control outputs; rst forces every output low.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    refill_d    = refill_q;
    inc_hit     = 1'b0;
    inc_miss    = 1'b0;
    inc_wb      = 1'b0;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    pmem_we     = 1'b0;
    pmarmux_sel = 1'b0;
    datamux_sel = 1'b1;
    load_addr   = 1'b0;

    unique case (state_q)
      S_CHECK: begin
        refill_d = 1'b0;
        if (request) begin
          if (hit) begin
            mem_resp = 1'b1;
            inc_hit  = ~refill_q;   // retries after a fill are not first-access hits
          end else begin
            load_addr = 1'b1;
            inc_miss  = 1'b1;
            if (replace && dirty) begin
              pmarmux_sel = 1'b1;   // victim address goes out first
              state_d     = S_WRITEBACK;
            end else begin
              state_d = S_ALLOC;
            end
          end
        end
      end

      S_WRITEBACK: begin
        pmem_write  = 1'b1;
        pmarmux_sel = 1'b1;
        if (pmem_resp) begin
          inc_wb      = 1'b1;
          load_addr   = 1'b1;
          pmarmux_sel = 1'b0;       // switch the address register to the request line
          state_d     = S_ALLOC;
        end
      end

      S_ALLOC: begin
        pmem_read   = 1'b1;
        datamux_sel = 1'b0;
        if (pmem_resp) begin
          pmem_we = 1'b1;
          state_d = S_REFILL;
        end
      end

      S_REFILL: begin
        refill_d = 1'b1;
        state_d  = S_CHECK;
      end

      default: state_d = S_CHECK;
    endcase

    if (rst) begin
      mem_resp    = 1'b0;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      pmem_we     = 1'b0;
      pmarmux_sel = 1'b0;
      datamux_sel = 1'b0;
      load_addr   = 1'b0;
    end
  end

  // Saturating counter next values; at most one inc_* is high per cycle.
  always_comb begin
    hit_cnt_d  = (inc_hit  && hit_cnt_q  != CNT_MAX) ? hit_cnt_q  + CNT_ONE : hit_cnt_q;
    miss_cnt_d = (inc_miss && miss_cnt_q != CNT_MAX) ? miss_cnt_q + CNT_ONE : miss_cnt_q;
    wb_cnt_d   = (inc_wb   && wb_cnt_q   != CNT_MAX) ? wb_cnt_q   + CNT_ONE : wb_cnt_q;
  end

  // State, retry flag and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_CHECK;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = rst ? '0 : hit_cnt_q;
  assign miss_count = rst ? '0 : miss_cnt_q;
  assign wb_count   = rst ? '0 : wb_cnt_q;

endmodule

// File: tb/tb_cache_control.sv
// Directed testbench for cache_control. Inputs change 1 ns after the rising
// edge; outputs are checked 2 ns later, well clear of the next edge. A
// CNT_WIDTH=4 copy shares the inputs so counter saturation can be exercised.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, hit, dirty, replace, pmem_resp;

  logic        mem_resp, pmem_read, pmem_write, pmem_we;
  logic        pmarmux_sel, datamux_sel, load_addr;
  logic [15:0] hit_count, miss_count, wb_count;

  logic        s_mem_resp, s_pmem_read, s_pmem_write, s_pmem_we;
  logic        s_pmarmux_sel, s_datamux_sel, s_load_addr;
  logic [3:0]  s_hit_count, s_miss_count, s_wb_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit(hit), .dirty(dirty), .replace(replace),
    .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_we(pmem_we), .pmarmux_sel(pmarmux_sel), .datamux_sel(datamux_sel),
    .load_addr(load_addr), .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  cache_control #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(s_mem_resp), .hit(hit), .dirty(dirty), .replace(replace),
    .pmem_resp(pmem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .pmem_we(s_pmem_we), .pmarmux_sel(s_pmarmux_sel), .datamux_sel(s_datamux_sel),
    .load_addr(s_load_addr), .hit_count(s_hit_count), .miss_count(s_miss_count),
    .wb_count(s_wb_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; hit = 1'b1;
    dirty = 1'b0; replace = 1'b0; pmem_resp = 1'b0;

    // Reset with a pending hit: everything held low.
    #2;
    check("rst_mem_resp", mem_resp, 0);
    check("rst_datamux", datamux_sel, 0);
    check("rst_pmem_read", pmem_read, 0);
    next_cycle();
    check("rst_mem_resp_2", mem_resp, 0);
    rst = 1'b0; mem_read = 1'b0; hit = 1'b0;
    next_cycle();
    check("rst_hit_cnt", hit_count, 0);
    check("rst_miss_cnt", miss_count, 0);
    check("rst_wb_cnt", wb_count, 0);

    // Read hit: same-cycle response, no pmem activity.
    mem_read = 1'b1; hit = 1'b1; #2;
    check("hit_mem_resp", mem_resp, 1);
    check("hit_datamux", datamux_sel, 1);
    check("hit_pmem", {pmem_read, pmem_write, pmem_we, load_addr}, 0);
    next_cycle();
    mem_read = 1'b0; hit = 1'b0;
    check("hit_cnt_1", hit_count, 1);

    // Read miss, clean allocate, pmem_resp on the 3rd ALLOC cycle.
    mem_read = 1'b1; #2;
    check("rm_c0_load", {load_addr, pmarmux_sel}, 2'b10);
    check("rm_c0_resp", mem_resp, 0);
    next_cycle(); #2;
    check("rm_c1_read", {pmem_read, datamux_sel, pmem_we}, 3'b100);
    next_cycle(); #2;
    check("rm_c2_read", {pmem_read, pmem_we}, 2'b10);
    next_cycle();
    pmem_resp = 1'b1; #2;
    check("rm_c3_fill", {pmem_read, pmem_we}, 2'b11);
    next_cycle();
    pmem_resp = 1'b0; #2;
    check("rm_c4_refill", {mem_resp, pmem_read, pmem_we, datamux_sel}, 4'b0001);
    next_cycle();
    hit = 1'b1; #2;
    check("rm_c5_resp", mem_resp, 1);
    next_cycle();
    mem_read = 1'b0; hit = 1'b0;
    check("rm_miss_cnt", miss_count, 1);
    check("rm_hit_cnt", hit_count, 1);

    // Write miss with a dirty victim: writeback, then allocate.
    mem_write = 1'b1; replace = 1'b1; dirty = 1'b1; #2;
    check("wm_c0_load", {load_addr, pmarmux_sel}, 2'b11);
    next_cycle(); #2;
    check("wm_c1_wb", {pmem_write, pmarmux_sel, pmem_read, load_addr}, 4'b1100);
    next_cycle();
    pmem_resp = 1'b1; #2;
    check("wm_c2_wbdone", {pmem_write, load_addr, pmarmux_sel}, 3'b110);
    next_cycle();
    pmem_resp = 1'b0; #2;
    check("wm_c3_alloc", {pmem_read, pmem_write}, 2'b10);
    next_cycle();
    pmem_resp = 1'b1; #2;
    check("wm_c4_fill", {pmem_read, pmem_we}, 2'b11);
    next_cycle();
    pmem_resp = 1'b0; replace = 1'b0; dirty = 1'b0; #2;
    check("wm_c5_refill", {pmem_read, pmem_write, mem_resp}, 0);
    next_cycle();
    hit = 1'b1; #2;
    check("wm_c6_resp", {mem_resp, datamux_sel}, 2'b11);
    next_cycle();
    mem_write = 1'b0; hit = 1'b0;
    check("wm_wb_cnt", wb_count, 1);
    check("wm_miss_cnt", miss_count, 2);
    check("wm_hit_cnt", hit_count, 1);

    // Reset in the middle of a writeback aborts it.
    mem_write = 1'b1; replace = 1'b1; dirty = 1'b1;
    next_cycle(); #2;
    check("ra_wb_active", pmem_write, 1);
    next_cycle();
    rst = 1'b1; #2;
    check("ra_wb_dropped", {pmem_write, pmem_read, pmem_we}, 0);
    next_cycle();
    rst = 1'b0; mem_write = 1'b0; replace = 1'b0; dirty = 1'b0;
    check("ra_miss_cnt", miss_count, 0);

    // Back in CHECK: stray pmem_resp ignored; 17 read hits saturate the 4-bit copy.
    mem_read = 1'b1; hit = 1'b1; pmem_resp = 1'b1; #2;
    check("stray_resp", {pmem_we, pmem_read, pmem_write, mem_resp}, 4'b0001);
    pmem_resp = 1'b0;
    next_cycle();
    for (int i = 1; i < 17; i++) begin
      #2;
      check("sat_mem_resp", mem_resp, 1);
      next_cycle();
    end
    mem_read = 1'b0; hit = 1'b0;
    check("sat_hit_cnt4", s_hit_count, 15);
    check("sat_hit_cnt16", hit_count, 17);
    check("sat_miss_cnt4", s_miss_count, 0);

    // Request dropped during a miss: fill completes, no response, no retry credit kept.
    mem_read = 1'b1;
    next_cycle();
    mem_read = 1'b0; pmem_resp = 1'b1; #2;
    check("drop_fill", pmem_we, 1);
    next_cycle();
    pmem_resp = 1'b0;
    next_cycle(); #2;
    check("drop_no_resp", mem_resp, 0);
    next_cycle();
    mem_read = 1'b1; hit = 1'b1; #2;
    check("drop_hit_resp", mem_resp, 1);
    next_cycle();
    mem_read = 1'b0; hit = 1'b0;
    check("drop_hit_cnt", hit_count, 18);
    check("drop_miss_cnt", miss_count, 1);
    check("drop_sat_hold", s_hit_count, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
